pooling_2x2: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage placed after the convolution engine.
- Accepts one convolution result per clock while En is high, in raster order over a MAP_W x MAP_H feature map.
- Reduces each non-overlapping 2x2 window to one pixel and exposes all pooled pixels of the frame as a parallel packed array.
- Raises a one-cycle done strobe when the last window of a frame completes.

---
 rtl/pooling_pkg.sv | 29 ++
 rtl/pool_reduce2.sv | 25 ++
 rtl/pooling_2x2.sv | 101 ++++++++++
 tb/tb_pooling_2x2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared constants, pixel type and combine function for the 2x2 pooling stage.
// Defining POOLING_AVG_EN switches the whole stage from max pooling to average pooling.
package pooling_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_MAP_W  = 4;
    localparam int DEF_MAP_H  = 4;

    // Average mode carries two guard bits so a four-sample sum never overflows.
`ifdef POOLING_AVG_EN
    localparam int GUARD_W = 2;
`else
    localparam int GUARD_W = 0;
`endif

    localparam int ACC_W = DEF_DATA_W + GUARD_W;

    typedef logic [DEF_DATA_W-1:0] pixel_t;
    typedef logic [ACC_W-1:0]      acc_t;

    function automatic acc_t pool_combine(input acc_t a, input acc_t b);
`ifdef POOLING_AVG_EN
        return a + b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

endpackage

// File: rtl/pool_reduce2.sv
// Two-input combine unit of the pooling stage: unsigned max, or sum when POOLING_AVG_EN is defined.
// Used once for the partial-row path and once for the window output path.
module pool_reduce2
    import pooling_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    generate
        if (W == ACC_W) begin : gPkg
            assign y_o = pool_combine(a_i, b_i);
        end else begin : gGeneric
`ifdef POOLING_AVG_EN
            assign y_o = a_i + b_i;
`else
            assign y_o = (a_i > b_i) ? a_i : b_i;
`endif
        end
    endgenerate

endmodule

// File: rtl/pooling_2x2.sv
// Streaming 2x2 stride-2 pooling over a raster-order feature map; max pooling by default,
// average pooling when POOLING_AVG_EN is defined.
module pooling_2x2
    import pooling_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAP_W  = DEF_MAP_W,
    parameter int MAP_H  = DEF_MAP_H
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         En,
    input  logic [DATA_W-1:0]                            convResult,
    output logic [(MAP_W/2)*(MAP_H/2)-1:0][DATA_W-1:0]   pooledPixels,
    output logic                                         done
);

    localparam int N_OUT  = (MAP_W/2)*(MAP_H/2);
    localparam int HALF_W = MAP_W/2;
    localparam int W      = DATA_W + GUARD_W;
    localparam int CW     = $clog2(MAP_W);
    localparam int RW     = $clog2(MAP_H);
    localparam int JW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int KW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [CW-1:0]                  col_q, col_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [W-1:0]                   temp_q;
    logic [W-1:0]                   rowBuf_q [HALF_W];
    logic [N_OUT-1:0][DATA_W-1:0]   pooled_q;
    logic                           done_q;

    logic                           lastCol, lastRow;
    logic [JW-1:0]                  bufIdx;
    logic [KW-1:0]                  outIdx;
    logic [W-1:0]                   sampleExt, bufSum, pairSum;
    logic [DATA_W-1:0]              windowPix;

    always_comb begin
        lastCol = (col_q == CW'(MAP_W-1));
        lastRow = (row_q == RW'(MAP_H-1));
        col_d   = col_q;
        row_d   = row_q;
        if (En) begin
            if (lastCol) begin
                col_d = '0;
                row_d = lastRow ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign bufIdx    = JW'(col_q >> 1);
    assign outIdx    = KW'(row_q >> 1) * KW'(HALF_W) + KW'(bufIdx);
    assign sampleExt = W'(convResult);

    pool_reduce2 #(.W(W)) uTempPath (
        .a_i (rowBuf_q[bufIdx]),
        .b_i (sampleExt),
        .y_o (bufSum)
    );

    pool_reduce2 #(.W(W)) uOutPath (
        .a_i (temp_q),
        .b_i (sampleExt),
        .y_o (pairSum)
    );

    // In average mode dropping the guard bits is the divide-by-four.
    assign windowPix = pairSum[GUARD_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            temp_q   <= '0;
            pooled_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < HALF_W; i++) begin
                rowBuf_q[i] <= '0;
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            done_q <= En && lastCol && lastRow;
            if (En) begin
                case ({row_q[0], col_q[0]})
                    2'b00:   temp_q           <= sampleExt;
                    2'b01:   rowBuf_q[bufIdx] <= pairSum;
                    2'b10:   temp_q           <= bufSum;
                    default: pooled_q[outIdx] <= windowPix;
                endcase
            end
        end
    end

    assign pooledPixels = pooled_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pooling_2x2.sv
// Scoreboard bench for pooling_2x2: the driver models whole-frame pooling per cycle and queues
// the expected outputs; a monitor pops and compares one entry after every rising edge.
module tb_pooling_2x2;
    import pooling_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int MAP_W  = DEF_MAP_W;
    localparam int MAP_H  = DEF_MAP_H;
    localparam int N_OUT  = (MAP_W/2)*(MAP_H/2);
    localparam int N_SAMP = MAP_W*MAP_H;
    localparam int PIX_W  = N_OUT*DATA_W;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          En = 1'b0;
    logic [DATA_W-1:0]             convResult = '0;
    logic [N_OUT-1:0][DATA_W-1:0]  pooledPixels;
    logic                          done;

    pooling_2x2 #(.DATA_W(DATA_W), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .En           (En),
        .convResult   (convResult),
        .pooledPixels (pooledPixels),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIX_W-1:0] pix;
        logic             done;
    } expect_t;

    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;
    pixel_t  frameMem [N_SAMP];
    pixel_t  refPix [N_OUT];
    int      sampleIdx = 0;

    // Reference: pool the four stored samples of the window whose bottom-right is (r, c).
    function automatic pixel_t windowResult(int r, int c);
        int v [4];
        int best;
        v[0] = int'(frameMem[(r-1)*MAP_W + c-1]);
        v[1] = int'(frameMem[(r-1)*MAP_W + c]);
        v[2] = int'(frameMem[r*MAP_W + c-1]);
        v[3] = int'(frameMem[r*MAP_W + c]);
`ifdef POOLING_AVG_EN
        return pixel_t'((v[0] + v[1] + v[2] + v[3]) / 4);
`else
        best = v[0];
        for (int i = 1; i < 4; i++) begin
            if (v[i] > best) best = v[i];
        end
        return pixel_t'(best);
`endif
    endfunction

    function automatic logic [PIX_W-1:0] packRef();
        logic [PIX_W-1:0] flat;
        for (int k = 0; k < N_OUT; k++) begin
            flat[k*DATA_W +: DATA_W] = refPix[k];
        end
        return flat;
    endfunction

    function automatic void clearModel();
        sampleIdx = 0;
        for (int k = 0; k < N_OUT; k++) refPix[k] = '0;
    endfunction

    function automatic pixel_t randPixel();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return pixel_t'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [PIX_W-1:0] actual,
                               input logic [PIX_W-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // One clock of stimulus: drive on the falling edge and queue what the next rising edge must show.
    task automatic applyStimulus(input bit rstN, input bit en, input pixel_t data);
        int  r, c;
        logic doneExp;
        @(negedge clk);
        rst_n      = rstN;
        En         = en;
        convResult = data;
        doneExp    = 1'b0;
        if (!rstN) begin
            clearModel();
        end else if (en) begin
            frameMem[sampleIdx] = data;
            r = sampleIdx / MAP_W;
            c = sampleIdx % MAP_W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                refPix[(r/2)*(MAP_W/2) + c/2] = windowResult(r, c);
            end
            if (sampleIdx == N_SAMP-1) begin
                doneExp   = 1'b1;
                sampleIdx = 0;
            end else begin
                sampleIdx++;
            end
        end
        expQ.push_back('{pix: packRef(), done: doneExp});
    endtask

    task automatic applyAsyncReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        En    = 1'b0;
        #1;
        checkOutput("asyncResetPixels", pooledPixels, '0);
        checkOutput("asyncResetDone", PIX_W'(done), '0);
        clearModel();
        expQ.push_back('{pix: packRef(), done: 1'b0});
    endtask

    task automatic runRandomSamples(input int count);
        int sent;
        sent = 0;
        while (sent < count) begin
            if ($urandom_range(0, 9) < 3) begin
                applyStimulus(1'b1, 1'b0, randPixel());
            end else begin
                applyStimulus(1'b1, 1'b1, randPixel());
                sent++;
            end
        end
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pooledPixels", pooledPixels, e.pix);
                checkOutput("done", PIX_W'(done), PIX_W'(e.done));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : driver
        pixel_t directed [16];
        directed = '{8'h31, 8'h84, 8'h38, 8'h07, 8'h73, 8'h90, 8'h62, 8'h84,
                     8'h00, 8'hFF, 8'h10, 8'h10, 8'h01, 8'h02, 8'h20, 8'h0F};
        clearModel();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, randPixel());

        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, randPixel());
            end
            applyStimulus(1'b1, 1'b1, directed[i]);
        end
`ifndef POOLING_AVG_EN
        @(posedge clk);
        #2;
        checkOutput("directedFrame", pooledPixels, 32'h20FF8490);
        checkOutput("directedDone", PIX_W'(done), PIX_W'(1));
`endif

        for (int i = 0; i < N_SAMP; i++) applyStimulus(1'b1, 1'b1, '0);

        runRandomSamples(2*N_SAMP);
        runRandomSamples(7);
        applyAsyncReset();
        applyStimulus(1'b1, 1'b0, randPixel());
        runRandomSamples(3*N_SAMP + 5);

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        @(posedge clk);
        #3;
        checkOutput("queueDrain", PIX_W'(expQ.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
